// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of a 5-stage RISC-V pipeline. Owns the PC and issues
//   word fetches to instruction memory, with at most one request outstanding and
//   variable read latency. It is the only writer of the IF/ID pipeline register:
//   it drives that register's load enable, flush and data. Decode stalls hold
//   back delivery, and EX-stage redirects flush IF/ID and restart fetch.
//
// Ports
//   i_clk          clock; all state updates on the rising edge
//   i_r_n          asynchronous active-low reset
//   i_stall        IF/ID must hold its contents this cycle
//   i_redirect     taken branch/jump from EX: flush and refetch
//   i_redirect_pc  redirect target (word-aligned, not checked)
//   o_imem_req     fetch request valid
//   o_imem_addr    fetch address (current PC)
//   i_imem_ready   memory accepts the request this cycle
//   i_imem_rvalid  read data valid, one pulse per accepted request
//   i_imem_rdata   instruction word
//   o_ifid_en      IF/ID load enable
//   o_ifid_r       IF/ID flush (takes priority over enable inside IF/ID)
//   o_ifid_pc      PC of the delivered instruction (0 when not loading)
//   o_ifid_instr   delivered instruction (0 when not loading)
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// FETCH | request at PC presented, waiting for acceptance
// WAIT  | request accepted, waiting for read data
// HOLD  | data returned under a stall, parked in the buffer
// DRAIN | a stale (pre-redirect) request is in flight, its data is dropped
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        i_clk,
   input  logic        i_r_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_ifid_en,
   output logic        o_ifid_r,
   output logic [31:0] o_ifid_pc,
   output logic [31:0] o_ifid_instr
);

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_buf;
   logic [31:0] w_buf_nxt;
   logic        w_accept;

   always_ff @(posedge i_clk or negedge i_r_n) begin
      if (!i_r_n) begin
         r_state <= S_BOOT;
         r_pc    <= RESET_PC;
         r_buf   <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_buf   <= w_buf_nxt;
      end
   end

   assign w_accept = (r_state == S_FETCH) && i_imem_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_buf_nxt   = r_buf;
      case (r_state)
         S_BOOT: w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (i_redirect) begin
               // A fetch accepted in the redirect cycle targets the old path.
               w_pc_nxt    = i_redirect_pc;
               w_state_nxt = w_accept ? S_DRAIN : S_FETCH;
            end else if (w_accept) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_redirect) begin
               w_pc_nxt    = i_redirect_pc;
               w_state_nxt = i_imem_rvalid ? S_FETCH : S_DRAIN;
            end else if (i_imem_rvalid) begin
               if (i_stall) begin
                  w_buf_nxt   = i_imem_rdata;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_pc_nxt    = r_pc + PC_INC;
                  w_state_nxt = S_FETCH;
               end
            end
         end
         S_HOLD: begin
            if (i_redirect) begin
               w_pc_nxt    = i_redirect_pc;
               w_state_nxt = S_FETCH;
            end else if (!i_stall) begin
               w_pc_nxt    = r_pc + PC_INC;
               w_state_nxt = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (i_redirect) begin
               w_pc_nxt = i_redirect_pc;
            end
            // Leave once the stale data has come back; staying here after its
            // rvalid would wait for a response that never arrives.
            if (i_imem_rvalid) begin
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_BOOT;
      endcase
   end

   always_comb begin
      o_imem_req   = (r_state == S_FETCH);
      o_imem_addr  = r_pc;
      o_ifid_r     = i_redirect && (r_state != S_BOOT);
      o_ifid_en    = 1'b0;
      o_ifid_pc    = 32'd0;
      o_ifid_instr = 32'd0;
      if (!o_ifid_r && !i_stall) begin
         if (r_state == S_WAIT && i_imem_rvalid) begin
            o_ifid_en    = 1'b1;
            o_ifid_pc    = r_pc;
            o_ifid_instr = i_imem_rdata;
         end else if (r_state == S_HOLD) begin
            o_ifid_en    = 1'b1;
            o_ifid_pc    = r_pc;
            o_ifid_instr = r_buf;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

   logic        clk;
   logic        r_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ifid_en;
   logic        ifid_r;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;

   int checks   = 0;
   int failures = 0;

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
      .i_clk         (clk),
      .i_r_n         (r_n),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_ready  (imem_ready),
      .i_imem_rvalid (imem_rvalid),
      .i_imem_rdata  (imem_rdata),
      .o_ifid_en     (ifid_en),
      .o_ifid_r      (ifid_r),
      .o_ifid_pc     (ifid_pc),
      .o_ifid_instr  (ifid_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        ready;
      logic        rvalid;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_en;
      logic        e_r;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic rdy,
                               logic rv, logic [31:0] dat, logic req,
                               logic [31:0] addr, logic en, logic fl,
                               logic [31:0] pc, logic [31:0] ins);
      vec_t v;
      v.stall = st; v.redirect = rd; v.rpc = rpc; v.ready = rdy;
      v.rvalid = rv; v.rdata = dat; v.e_req = req; v.e_addr = addr;
      v.e_en = en; v.e_r = fl; v.e_pc = pc; v.e_instr = ins;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                          input logic en, input logic fl, input logic [31:0] pc,
                          input logic [31:0] ins);
      chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
      chk({tag, ".addr"},  imem_addr, addr);
      chk({tag, ".en"},    {31'd0, ifid_en}, {31'd0, en});
      chk({tag, ".flush"}, {31'd0, ifid_r}, {31'd0, fl});
      chk({tag, ".pc"},    ifid_pc, pc);
      chk({tag, ".instr"}, ifid_instr, ins);
   endtask

   task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic rdy, input logic rv, input logic [31:0] dat);
      stall = st; redirect = rd; redirect_pc = rpc;
      imem_ready = rdy; imem_rvalid = rv; imem_rdata = dat;
   endtask

   // Reset held across a few edges, released on a falling edge; the caller's
   // first cycle is the BOOT cycle.
   task automatic do_reset();
      r_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      r_n = 1'b1;
   endtask

   // Reference model: a transaction-level view of the fetch unit.
   bit          m_boot;
   logic [31:0] m_pc;
   bit          m_inflight;
   bit          m_stale;
   bit          m_held;
   logic [31:0] m_hbuf;

   initial begin
      r_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);

      // Directed table: sequential fetch, stall/hold, redirects, PC wrap.
      tbl[0]  = mk(0,0,0,0,0,0,                 0,32'h0,0,0,0,0);
      tbl[1]  = mk(0,0,0,1,0,0,                 1,32'h0,0,0,0,0);
      tbl[2]  = mk(0,0,0,0,1,32'h1111_1111,     0,32'h0,1,0,32'h0,32'h1111_1111);
      tbl[3]  = mk(0,0,0,1,0,0,                 1,32'h4,0,0,0,0);
      tbl[4]  = mk(0,0,0,0,1,32'h2222_2222,     0,32'h4,1,0,32'h4,32'h2222_2222);
      tbl[5]  = mk(0,0,0,1,0,0,                 1,32'h8,0,0,0,0);
      tbl[6]  = mk(1,0,0,0,1,32'h00A0_0093,     0,32'h8,0,0,0,0);
      tbl[7]  = mk(1,0,0,0,0,0,                 0,32'h8,0,0,0,0);
      tbl[8]  = mk(1,0,0,0,0,0,                 0,32'h8,0,0,0,0);
      tbl[9]  = mk(0,0,0,0,0,0,                 0,32'h8,1,0,32'h8,32'h00A0_0093);
      tbl[10] = mk(0,0,0,1,0,0,                 1,32'hC,0,0,0,0);
      tbl[11] = mk(0,1,32'h100,0,0,0,           0,32'hC,0,1,0,0);
      tbl[12] = mk(0,0,0,0,1,32'hDEAD_BEEF,     0,32'h100,0,0,0,0);
      tbl[13] = mk(0,0,0,1,0,0,                 1,32'h100,0,0,0,0);
      tbl[14] = mk(1,1,32'hFFFF_FFFC,0,1,32'h3333_3333, 0,32'h100,0,1,0,0);
      tbl[15] = mk(0,0,0,0,0,0,                 1,32'hFFFF_FFFC,0,0,0,0);
      tbl[16] = mk(0,0,0,1,0,0,                 1,32'hFFFF_FFFC,0,0,0,0);
      tbl[17] = mk(0,0,0,0,1,32'h4444_4444,     0,32'hFFFF_FFFC,1,0,32'hFFFF_FFFC,32'h4444_4444);
      tbl[18] = mk(0,0,0,0,0,0,                 1,32'h0,0,0,0,0);

      #1;
      chk_all("reset", 0, 32'h0, 0, 0, 0, 0);

      do_reset();
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].stall, tbl[i].redirect, tbl[i].rpc, tbl[i].ready,
               tbl[i].rvalid, tbl[i].rdata);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_en,
                 tbl[i].e_r, tbl[i].e_pc, tbl[i].e_instr);
         @(negedge clk);
      end

      // Reset in the middle of a WAIT at pc 0x40, with stray rvalids afterwards.
      do_reset();
      drive(0, 1, 32'h40, 0, 0, 0);                 // BOOT: redirect ignored
      #1; chk_all("rst.boot_redir", 0, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 1, 32'h40, 0, 0, 0);                 // FETCH pc0 -> pc 0x40
      #1; chk_all("rst.fetch_redir", 1, 32'h0, 0, 1, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0);
      #1; chk_all("rst.fetch40", 1, 32'h40, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1; chk_all("rst.wait40", 0, 32'h40, 0, 0, 0, 0);
      #2 r_n = 1'b0;
      drive(0, 1, 32'h80, 0, 1, 32'h5555_5555);
      #1; chk_all("rst.async", 0, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      r_n = 1'b1;
      drive(0, 0, 0, 0, 1, 32'h6666_6666);          // BOOT, stray rvalid
      #1; chk_all("rst.boot_rv", 0, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 32'h7777_7777);          // FETCH, stray rvalid
      #1; chk_all("rst.fetch_rv", 1, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0);
      #1; chk_all("rst.fetch0", 1, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 32'h8888_8888);
      #1; chk_all("rst.deliver0", 0, 32'h0, 1, 0, 32'h0, 32'h8888_8888);
      @(negedge clk);

      // Randomized run against the reference model.
      begin
         int          lat_cnt;
         logic        e_req, e_en, e_r, acc;
         logic [31:0] e_pc, e_ins;
         do_reset();
         m_boot = 1; m_pc = 32'h0; m_inflight = 0; m_stale = 0; m_held = 0; m_hbuf = 0;
         lat_cnt = 0;
         for (int c = 0; c < 3000; c++) begin
            logic        st, rd, rdy, rv;
            logic [31:0] rpc, dat;
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            rdy = ($urandom_range(0, 2) != 0);
            dat = $urandom;
            rv  = 1'b0;
            if (lat_cnt > 0) begin
               lat_cnt--;
               rv = (lat_cnt == 0);
            end
            drive(st, rd, rpc, rdy, rv, dat);

            e_req = !m_boot && !m_inflight && !m_held;
            e_r   = rd && !m_boot;
            e_en  = 0; e_pc = 0; e_ins = 0;
            if (!m_boot && !rd && !st) begin
               if (m_held) begin
                  e_en = 1; e_pc = m_pc; e_ins = m_hbuf;
               end else if (m_inflight && !m_stale && rv) begin
                  e_en = 1; e_pc = m_pc; e_ins = dat;
               end
            end
            #1;
            chk_all($sformatf("rnd%0d", c), e_req, m_pc, e_en, e_r, e_pc, e_ins);

            acc = e_req && rdy;
            if (m_boot) begin
               m_boot = 0;
            end else begin
               if (rv && m_inflight) begin
                  if (!m_stale && !rd && st) begin
                     m_held = 1; m_hbuf = dat;
                  end
                  m_inflight = 0; m_stale = 0;
               end
               if (e_en) begin
                  m_held = 0; m_pc = m_pc + 32'd4;
               end
               if (rd) begin
                  m_pc = rpc; m_held = 0;
                  if (m_inflight) m_stale = 1;
               end
               if (acc) begin
                  m_inflight = 1; m_stale = rd;
                  lat_cnt = $urandom_range(1, 3);
               end
            end
            @(negedge clk);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
